// File: rtl/alu_eight_bit_seq.sv
// rtl/alu_eight_bit_seq.sv - 8-bit sequential ALU with multi-cycle rotate through carry
// Define ALU_ROTATE_EN to build the SHIFT state for RAL/RAR; otherwise ops 6/7 are NOPs.
module alu_eight_bit_seq (
   input  logic       clk,
   input  logic       clr,
   input  logic [7:0] Acc,
   input  logic [7:0] Tmp,
   input  logic [2:0] op,
   input  logic       start,
   input  logic       E,
   output logic [7:0] Result,
   output logic [7:0] Out_Bus,
   output logic       Z,
   output logic       S,
   output logic       C,
   output logic       busy,
   output logic       done
);

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_CMA = 3'd5;

`ifdef ALU_ROTATE_EN
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

   state_t state;

   // {carry, data} produced by the single-cycle ops; ops 6/7 fall through as a zero-length rotate
   logic [8:0] alu_val;

   always_comb begin
      alu_val = {C, Acc};
      case (op)
         OP_ADD:  alu_val = {1'b0, Acc} + {1'b0, Tmp};
         OP_SUB:  alu_val = {(Acc >= Tmp), 8'(Acc - Tmp)};
         OP_AND:  alu_val = {1'b0, Acc & Tmp};
         OP_OR:   alu_val = {1'b0, Acc | Tmp};
         OP_XOR:  alu_val = {1'b0, Acc ^ Tmp};
         OP_CMA:  alu_val = {C, ~Acc};
         default: alu_val = {C, Acc};
      endcase
   end

`ifdef ALU_ROTATE_EN
   logic [7:0] work;
   logic       work_c;
   logic [2:0] cnt;
   logic       dir_right;
   logic [8:0] rot_next;

   always_comb begin
      rot_next = dir_right ? {work[0], work_c, work[7:1]} : {work, work_c};
   end
`endif

   assign Out_Bus = E ? Result : 8'bz;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state  <= IDLE;
         Result <= 8'd0;
         Z      <= 1'b0;
         S      <= 1'b0;
         C      <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
`ifdef ALU_ROTATE_EN
         work      <= 8'd0;
         work_c    <= 1'b0;
         cnt       <= 3'd0;
         dir_right <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  if (op[2:1] != 2'b11) begin
                     Result <= alu_val[7:0];
                     C      <= alu_val[8];
                     Z      <= (alu_val[7:0] == 8'd0);
                     S      <= alu_val[7];
                     state  <= DONE;
                     busy   <= 1'b1;
                     done   <= 1'b1;
                  end else begin
`ifdef ALU_ROTATE_EN
                     if (Tmp[2:0] == 3'd0) begin
                        Result <= Acc;
                        Z      <= (Acc == 8'd0);
                        S      <= Acc[7];
                        state  <= DONE;
                        busy   <= 1'b1;
                        done   <= 1'b1;
                     end else begin
                        work      <= Acc;
                        work_c    <= C;
                        cnt       <= Tmp[2:0];
                        dir_right <= op[0];
                        state     <= SHIFT;
                        busy      <= 1'b1;
                     end
`else
                     state <= DONE;
                     busy  <= 1'b1;
                     done  <= 1'b1;
`endif
                  end
               end
            end
`ifdef ALU_ROTATE_EN
            SHIFT: begin
               {work_c, work} <= rot_next;
               cnt            <= cnt - 3'd1;
               // Only the final rotate is made visible; intermediate steps stay in the work register
               if (cnt == 3'd1) begin
                  Result <= rot_next[7:0];
                  C      <= rot_next[8];
                  Z      <= (rot_next[7:0] == 8'd0);
                  S      <= rot_next[7];
                  state  <= DONE;
                  done   <= 1'b1;
               end
            end
`endif
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule
